// File: rtl/gg_pkg.sv
// Shared field offsets, table entry layout and lookup state encoding for the cheat engine.
package gg_pkg;

  // Bit positions inside the 129-bit strobed code word from the loader.
  localparam int STROBE      = 128;
  localparam int FLAGS_LSB   = 96;
  localparam int ADDR_LSB    = 64;
  localparam int CMP_LSB     = 32;
  localparam int REP_LSB     = 0;
  localparam int FLAG_CMP_EN = 0;

  // Widest address a code word can carry; narrower ROM addresses are zero-extended.
  localparam int GG_ADDR_MAX = 32;

  typedef struct packed {
    logic                   valid;
    logic                   cmp_en;
    logic [GG_ADDR_MAX-1:0] addr;
    logic [7:0]             cmp;
    logic [7:0]             rep;
  } gg_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } gg_state_t;

endpackage

// File: rtl/gg_prio_enc.sv
// Lowest-index-wins encoder over a multi-hot request vector, plus an any-hit flag.
module gg_prio_enc #(
  parameter int N = 32
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/gg_code_engine.sv
// Game Genie cheat engine: holds a code table and patches HuCard ROM read data.
// Handshake: ROM_RD is a one-cycle request pulse at ROM_A; ROM_RDY_PULSE is a one-cycle
// pulse meaning ROM_DI holds data for the last request; ROM_DO_VALID is a one-cycle pulse
// exactly one cycle after ROM_RDY_PULSE with ROM_DO holding the (possibly patched) byte.
// There is no back-pressure on any of these.
module gg_code_engine
  import gg_pkg::*;
#(
  parameter int MAX_CODES = 32,
  parameter int ADDR_W    = 22
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         CODE_CLEAR,
  input  logic [128:0]                 GG_CODE,
  input  logic                         GG_EN,
  input  logic [ADDR_W-1:0]            ROM_A,
  input  logic                         ROM_RD,
  input  logic [7:0]                   ROM_DI,
  input  logic                         ROM_RDY_PULSE,
  output logic [7:0]                   ROM_DO,
  output logic                         ROM_DO_VALID,
  output logic [$clog2(MAX_CODES):0]   CODE_COUNT,
  output logic                         FULL,
  output gg_state_t                    DBG_STATE
);

  localparam int IW = $clog2(MAX_CODES);
  localparam int CW = IW + 1;

  gg_entry_t              table_q [MAX_CODES];
  gg_entry_t              new_entry;
  logic [MAX_CODES-1:0]   hit_vec;
  logic [IW-1:0]          hit_idx;
  logic                   hit_any;
  gg_state_t              state_q, state_d;
  logic                   m_hit, m_cmp_en;
  logic [7:0]             m_cmp, m_rep;
  logic                   patch;
  logic                   unused_bits;

  // Flag bits other than compare-enable and address bits above ADDR_W carry no meaning here.
  assign unused_bits = ^GG_CODE;

  assign FULL      = (CODE_COUNT == CW'(MAX_CODES));
  assign DBG_STATE = state_q;

  // Decode the incoming code word into a table entry.
  always_comb begin
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.cmp_en = GG_CODE[FLAGS_LSB + FLAG_CMP_EN];
    new_entry.addr   = GG_ADDR_MAX'(GG_CODE[ADDR_LSB +: ADDR_W]);
    new_entry.cmp    = GG_CODE[CMP_LSB +: 8];
    new_entry.rep    = GG_CODE[REP_LSB +: 8];
  end

  // Table load/clear; clear beats a same-cycle strobe, strobes while full are dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < MAX_CODES; i++) table_q[i] <= '0;
      CODE_COUNT <= '0;
    end else if (CODE_CLEAR) begin
      for (int i = 0; i < MAX_CODES; i++) table_q[i].valid <= 1'b0;
      CODE_COUNT <= '0;
    end else if (GG_CODE[STROBE] && !FULL) begin
      table_q[CODE_COUNT[IW-1:0]] <= new_entry;
      CODE_COUNT                  <= CODE_COUNT + CW'(1);
    end
  end

  // Stage 1 compare: every valid entry against the requested address in parallel.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < MAX_CODES; i++) begin
      hit_vec[i] = table_q[i].valid && (table_q[i].addr == GG_ADDR_MAX'(ROM_A));
    end
  end

  gg_prio_enc #(.N(MAX_CODES)) u_prio (
    .req (hit_vec),
    .idx (hit_idx),
    .any (hit_any)
  );

  // Lookup state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A new request always arms (last request wins); data alone returns to idle.
  always_comb begin
    state_d = state_q;
    if (ROM_RD)             state_d = ST_ARMED;
    else if (ROM_RDY_PULSE) state_d = ST_IDLE;
  end

  // Capture the winning entry's fields so later table changes cannot disturb this request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_hit    <= 1'b0;
      m_cmp_en <= 1'b0;
      m_cmp    <= '0;
      m_rep    <= '0;
    end else if (ROM_RD) begin
      m_hit    <= hit_any;
      m_cmp_en <= table_q[hit_idx].cmp_en;
      m_cmp    <= table_q[hit_idx].cmp;
      m_rep    <= table_q[hit_idx].rep;
    end
  end

  assign patch = (state_q == ST_ARMED) && GG_EN && m_hit && (!m_cmp_en || (ROM_DI == m_cmp));

  // Stage 2: register returned data, substituting the replacement byte on a qualified hit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ROM_DO       <= '0;
      ROM_DO_VALID <= 1'b0;
    end else begin
      ROM_DO_VALID <= ROM_RDY_PULSE;
      if (ROM_RDY_PULSE) ROM_DO <= patch ? m_rep : ROM_DI;
    end
  end

endmodule

// File: tb/tb_gg_code_engine.sv
// Randomised plus directed bench for gg_code_engine with a scoreboard and a table model.
module tb_gg_code_engine;
  import gg_pkg::*;

  localparam int MAXC = 32;
  localparam int AW   = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           code_clear = 1'b0;
  logic [128:0]   gg_code    = '0;
  logic           gg_en      = 1'b0;
  logic [AW-1:0]  rom_a      = '0;
  logic           rom_rd     = 1'b0;
  logic [7:0]     rom_di     = '0;
  logic           rom_rdy    = 1'b0;
  logic [7:0]     rom_do;
  logic           rom_do_valid;
  logic [5:0]     code_count;
  logic           full;
  gg_state_t      dbg_state;

  gg_code_engine #(.MAX_CODES(MAXC), .ADDR_W(AW)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .CODE_CLEAR    (code_clear),
    .GG_CODE       (gg_code),
    .GG_EN         (gg_en),
    .ROM_A         (rom_a),
    .ROM_RD        (rom_rd),
    .ROM_DI        (rom_di),
    .ROM_RDY_PULSE (rom_rdy),
    .ROM_DO        (rom_do),
    .ROM_DO_VALID  (rom_do_valid),
    .CODE_COUNT    (code_count),
    .FULL          (full),
    .DBG_STATE     (dbg_state)
  );

  // ---------------- checking counters ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Table as an ordered list of loaded codes; lookups take the first (oldest) match.
  logic [AW-1:0] m_addr  [MAXC];
  bit            m_cmpen [MAXC];
  logic [7:0]    m_cmp   [MAXC];
  logic [7:0]    m_rep   [MAXC];
  int            m_cnt = 0;
  // Outcome of the outstanding request, resolved at request time.
  bit            p_armed = 0;
  bit            p_hit   = 0;
  bit            p_cmpen = 0;
  logic [7:0]    p_cmp   = '0;
  logic [7:0]    p_rep   = '0;
  int            cur_count = 0;
  bit            started   = 0;

  // Scoreboard queues: expected byte and the cycle it must appear on.
  logic [7:0] exp_q[$];
  int         due_q[$];

  function automatic logic [128:0] mk_code(input logic [AW-1:0] addr, input bit cen,
                                           input logic [7:0] cmp, input logic [7:0] rep,
                                           input bit strobe);
    logic [128:0] c;
    c = {1'b0, $urandom, $urandom, $urandom, $urandom};
    c[128]    = strobe;
    c[96]     = cen;
    c[85:64]  = addr;
    c[39:32]  = cmp;
    c[7:0]    = rep;
    return c;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle of stimulus; the model applies what the DUT will do at the next edge.
  task automatic step(input bit rd, input logic [AW-1:0] a, input bit rdy, input logic [7:0] di,
                      input bit ld, input logic [128:0] code, input bit clr, input bit en);
    bit hit_found;
    @(posedge clk);
    #1;
    rom_rd     = rd;
    rom_a      = a;
    rom_rdy    = rdy;
    rom_di     = di;
    gg_code    = code;
    gg_code[128] = ld;
    code_clear = clr;
    gg_en      = en;
    cur_count  = m_cnt;
    if (rdy) begin
      if (p_armed && en && p_hit && (!p_cmpen || di == p_cmp)) exp_q.push_back(p_rep);
      else exp_q.push_back(di);
      due_q.push_back(cyc + 1);
    end
    if (rd) begin
      hit_found = 0;
      p_hit = 0; p_cmpen = 0; p_cmp = '0; p_rep = '0;
      for (int i = 0; i < m_cnt; i++) begin
        if (!hit_found && m_addr[i] == a) begin
          hit_found = 1;
          p_hit = 1; p_cmpen = m_cmpen[i]; p_cmp = m_cmp[i]; p_rep = m_rep[i];
        end
      end
      p_armed = 1;
    end else if (rdy) begin
      p_armed = 0;
    end
    if (clr) m_cnt = 0;
    else if (ld && m_cnt < MAXC) begin
      m_addr[m_cnt]  = code[85:64];
      m_cmpen[m_cnt] = code[96];
      m_cmp[m_cnt]   = code[39:32];
      m_rep[m_cnt]   = code[7:0];
      m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 8'h00, 0, '0, 0, 1);
  endtask

  task automatic load(input logic [AW-1:0] addr, input bit cen, input logic [7:0] cmp,
                      input logic [7:0] rep);
    step(0, '0, 0, 8'h00, 1, mk_code(addr, cen, cmp, rep, 1), 0, 1);
  endtask

  task automatic clear();
    step(0, '0, 0, 8'h00, 0, '0, 1, 1);
  endtask

  // Read request followed by its data the next cycle.
  task automatic read(input logic [AW-1:0] a, input logic [7:0] di, input bit en);
    step(1, a, 0, 8'h00, 0, '0, 0, en);
    step(0, '0, 1, di, 0, '0, 0, en);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started && !rst) begin
      check("code_count", 32'(code_count), 32'(cur_count));
      check("full", 32'(full), 32'(cur_count == MAXC));
      if (rom_do_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got ROM_DO %0h with nothing expected (cycle %0d)", rom_do, cyc);
        end else begin
          check("rom_do", 32'(rom_do), 32'(exp_q.pop_front()));
          check("rom_do_latency", 32'(cyc), 32'(due_q.pop_front()));
        end
      end else if (exp_q.size() > 0 && due_q[0] <= cyc) begin
        n_chk++;
        $display("FAIL missing_valid: no ROM_DO_VALID, expected %0h (cycle %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [AW-1:0] pool [8];

  initial begin
    for (int i = 0; i < 8; i++) pool[i] = AW'(22'h2000 + i);
    // reset state
    @(negedge clk);
    check("rst_rom_do", 32'(rom_do), 32'h0);
    check("rst_valid", 32'(rom_do_valid), 32'h0);
    check("rst_count", 32'(code_count), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    started = 1;

    // 1: unconditional code
    load(22'h001234, 0, 8'h00, 8'hEA);
    read(22'h001234, 8'h60, 1);
    read(22'h001235, 8'h60, 1);
    // 2: compare-enabled code, then substitution disabled
    load(22'h000100, 1, 8'h60, 8'hEA);
    read(22'h000100, 8'h60, 1);
    read(22'h000100, 8'h61, 1);
    read(22'h000100, 8'h60, 0);
    // 3: duplicate address, lowest index wins
    clear();
    load(22'h000200, 0, 8'h00, 8'h11);
    load(22'h000200, 0, 8'h00, 8'h22);
    read(22'h000200, 8'h55, 1);
    clear();
    load(22'h000200, 0, 8'h00, 8'h22);
    read(22'h000200, 8'h55, 1);
    // 4: overfill, then clear with simultaneous strobe
    clear();
    for (int i = 0; i < 33; i++) load(AW'(22'h003000 + i), 0, 8'h00, 8'(8'h80 + i));
    read(22'h003020, 8'h44, 1);
    read(22'h003000, 8'h44, 1);
    read(22'h00301F, 8'h44, 1);
    step(0, '0, 0, 8'h00, 1, mk_code(22'h000777, 0, 8'h00, 8'h99, 1), 1, 1);
    read(22'h000777, 8'h45, 1);
    // 5: request and data in the same cycle; load on the request cycle
    load(22'h000500, 0, 8'h00, 8'hAA);
    step(1, 22'h000501, 0, 8'h00, 0, '0, 0, 1);
    step(1, 22'h000500, 1, 8'h10, 0, '0, 0, 1);
    step(0, '0, 1, 8'h11, 0, '0, 0, 1);
    step(1, 22'h000600, 0, 8'h00, 1, mk_code(22'h000600, 0, 8'h00, 8'hBB, 1), 0, 1);
    step(0, '0, 1, 8'h12, 0, '0, 0, 1);
    read(22'h000600, 8'h13, 1);
    // last request wins; clear while armed keeps the armed result
    step(1, 22'h000600, 0, 8'h00, 0, '0, 0, 1);
    step(1, 22'h000601, 0, 8'h00, 0, '0, 0, 1);
    step(0, '0, 1, 8'h14, 0, '0, 0, 1);
    step(1, 22'h000600, 0, 8'h00, 0, '0, 0, 1);
    clear();
    step(0, '0, 1, 8'h15, 0, '0, 0, 1);
    // 6: reset while armed
    load(22'h000500, 0, 8'h00, 8'hAA);
    step(1, 22'h000500, 0, 8'h00, 0, '0, 0, 1);
    step(0, '0, 1, 8'h20, 0, '0, 0, 1);
    step(1, 22'h000500, 0, 8'h00, 0, '0, 0, 1);
    #1;
    rst = 1'b1;
    rom_rd = 0; rom_rdy = 0; gg_code = '0; code_clear = 0;
    #1;
    check("async_rst_valid", 32'(rom_do_valid), 32'h0);
    check("async_rst_count", 32'(code_count), 32'h0);
    check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    m_cnt = 0; p_armed = 0; cur_count = 0;
    exp_q.delete(); due_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, '0, 1, 8'h33, 0, '0, 0, 1);
    idle(1);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      bit            rd, rdy, ld, clr, en, cen;
      logic [AW-1:0] a;
      logic [7:0]    di;
      rd  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      ld  = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 79) == 0);
      en  = ($urandom_range(0, 3) != 0);
      cen = $urandom_range(0, 1);
      a   = ($urandom_range(0, 7) == 0) ? AW'($urandom) : pool[$urandom_range(0, 7)];
      di  = ($urandom_range(0, 1) == 0) ? 8'h60 : 8'($urandom);
      step(rd, a, rdy, di, ld,
           mk_code(pool[$urandom_range(0, 7)], cen, ($urandom_range(0, 1) == 0) ? 8'h60 : 8'h61,
                   8'($urandom), 1),
           clr, en);
    end
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
